pacman_sprite_render: RTL and testbench

PACMAN_SPRITE_RENDER -- requirements
Module: pacman_sprite_render

---
 rtl/pacman_sprite_render.sv | 196 +++++++++++++++++++
 tb/tb_pacman_sprite_render.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pacman_sprite_render.sv
// Purpose: composites a 16x16 animated Pac-Man disc over the background pixel stream.
// Latency: 2 cycles from pix/sync/active/bg inputs to col_o/hs_o/vs_o (frame_o aligned with vs_o).
// Backpressure: one position update buffered; pos_ready_o low until that update commits at the next vsync rise.
module pacman_sprite_render #(
    parameter logic [10:0] POS_X_INIT  = 11'd632,
    parameter logic [9:0]  POS_Y_INIT  = 10'd352,
    parameter int unsigned ANIM_FRAMES = 8,
    parameter logic [7:0]  SPRITE_COL  = 8'hFC
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [10:0] pix_x_i,
    input  logic [9:0]  pix_y_i,
    input  logic        active_i,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic [7:0]  bg_col_i,
    input  logic [10:0] pos_x_i,
    input  logic [9:0]  pos_y_i,
    input  logic [1:0]  dir_i,
    input  logic        pos_valid_i,
    output logic        pos_ready_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic [7:0]  col_o,
    output logic        frame_o
);

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        M_CLOSED = 2'd0,
        M_HALF_A = 2'd1,
        M_OPEN   = 2'd2,
        M_HALF_B = 2'd3
    } mouth_e;

    localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

    // committed and shadow sprite state
    logic [10:0] cur_x, shd_x;
    logic [9:0]  cur_y, shd_y;
    dir_e        cur_dir, shd_dir;
    logic        pending;
    logic [7:0]  anim_cnt;
    mouth_e      mouth, mouth_nxt;

    // stage 1 registers (s1_vs doubles as the vsync edge detector history)
    logic [10:0] s1_u;
    logic [9:0]  s1_v;
    logic        s1_in, s1_act, s1_hs, s1_vs;
    logic [7:0]  s1_bg;
    logic        rise_q;

    logic        vs_rise, pos_hs, anim_wrap;
    logic [10:0] u_c;
    logic [9:0]  v_c;

    assign vs_rise     = vs_i && !s1_vs;
    assign pos_ready_o = !pending;
    assign pos_hs      = pos_valid_i && !pending;
    assign anim_wrap   = vs_rise && (anim_cnt == ANIM_LAST);
    assign u_c         = pix_x_i - cur_x;
    assign v_c         = pix_y_i - cur_y;

    // shadow capture on handshake; commit to the live position only at a vsync rise
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cur_x   <= POS_X_INIT;
            cur_y   <= POS_Y_INIT;
            cur_dir <= DIR_RIGHT;
            shd_x   <= '0;
            shd_y   <= '0;
            shd_dir <= DIR_RIGHT;
            pending <= 1'b0;
        end else if (vs_rise && pending) begin
            cur_x   <= shd_x;
            cur_y   <= shd_y;
            cur_dir <= shd_dir;
            pending <= 1'b0;
        end else if (pos_hs) begin
            shd_x   <= pos_x_i;
            shd_y   <= pos_y_i;
            shd_dir <= dir_e'(dir_i);
            pending <= 1'b1;
        end
    end

    // frame counter paces the mouth animation
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            anim_cnt <= '0;
        end else if (vs_rise) begin
            anim_cnt <= anim_wrap ? 8'd0 : anim_cnt + 8'd1;
        end
    end

    // mouth state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) mouth <= M_CLOSED;
        else         mouth <= mouth_nxt;
    end

    // mouth sequence advances one step per counter wrap
    always_comb begin
        mouth_nxt = mouth;
        if (anim_wrap) begin
            case (mouth)
                M_CLOSED: mouth_nxt = M_HALF_A;
                M_HALF_A: mouth_nxt = M_OPEN;
                M_OPEN:   mouth_nxt = M_HALF_B;
                M_HALF_B: mouth_nxt = M_CLOSED;
                default:  mouth_nxt = M_CLOSED;
            endcase
        end
    end

    // stage 1: sprite-relative coordinates; wrap-around lands far outside the box
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_u   <= '0;
            s1_v   <= '0;
            s1_in  <= 1'b0;
            s1_act <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_bg  <= '0;
            rise_q <= 1'b0;
        end else begin
            s1_u   <= u_c;
            s1_v   <= v_c;
            s1_in  <= (u_c < 11'd16) && (v_c < 10'd16);
            s1_act <= active_i;
            s1_hs  <= hs_i;
            s1_vs  <= vs_i;
            s1_bg  <= bg_col_i;
            rise_q <= vs_rise;
        end
    end

    // stage 2 geometry: centred doubled coordinates keep the disc symmetric about 7.5
    logic signed [5:0]  a, b, a_abs, b_abs, du, dw;
    logic signed [11:0] rad2;
    logic               body, m_half, m_open, mouth_px;
    logic [7:0]         col_c;

    // disc test, direction-rotated mouth wedge and final colour select
    always_comb begin
        a     = $signed({1'b0, s1_u[3:0], 1'b0}) - 6'sd15;
        b     = $signed({1'b0, s1_v[3:0], 1'b0}) - 6'sd15;
        a_abs = a[5] ? -a : a;
        b_abs = b[5] ? -b : b;
        rad2  = 12'(a * a) + 12'(b * b);
        body  = rad2 <= 12'sd225;
        du    = a;
        dw    = b_abs;
        case (cur_dir)
            DIR_RIGHT: begin du = a;  dw = b_abs; end
            DIR_LEFT:  begin du = -a; dw = b_abs; end
            DIR_UP:    begin du = -b; dw = a_abs; end
            DIR_DOWN:  begin du = b;  dw = a_abs; end
            default:   begin du = a;  dw = b_abs; end
        endcase
        m_half = (du > 6'sd0) && ((dw + dw) <= du);
        m_open = (du > 6'sd0) && (dw <= du);
        case (mouth)
            M_HALF_A, M_HALF_B: mouth_px = m_half;
            M_OPEN:             mouth_px = m_open;
            default:            mouth_px = 1'b0;
        endcase
        if (!s1_act)                     col_c = 8'h00;
        else if (s1_in && body && !mouth_px) col_c = SPRITE_COL;
        else                             col_c = s1_bg;
    end

    // stage 2 output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
            col_o   <= '0;
            frame_o <= 1'b0;
        end else begin
            hs_o    <= s1_hs;
            vs_o    <= s1_vs;
            col_o   <= col_c;
            frame_o <= rise_q;
        end
    end

endmodule

// File: tb/tb_pacman_sprite_render.sv
// Purpose: directed self-checking bench for pacman_sprite_render (mouth animation stepped every 2 frames).
// Latency: samples outputs 1 time unit after the rising edge, two edges after driving a pixel.
// Backpressure: position updates are issued one at a time and committed by explicit vsync pulses.
module tb_pacman_sprite_render;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [10:0] pix_x_i = '0;
    logic [9:0]  pix_y_i = '0;
    logic        active_i = 1'b0;
    logic        hs_i = 1'b0;
    logic        vs_i = 1'b0;
    logic [7:0]  bg_col_i = '0;
    logic [10:0] pos_x_i = '0;
    logic [9:0]  pos_y_i = '0;
    logic [1:0]  dir_i = '0;
    logic        pos_valid_i = 1'b0;
    logic        pos_ready_o, hs_o, vs_o, frame_o;
    logic [7:0]  col_o;

    int n_chk = 0;
    int n_err = 0;

    pacman_sprite_render #(.ANIM_FRAMES(2)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .pix_x_i(pix_x_i), .pix_y_i(pix_y_i), .active_i(active_i),
        .hs_i(hs_i), .vs_i(vs_i), .bg_col_i(bg_col_i),
        .pos_x_i(pos_x_i), .pos_y_i(pos_y_i), .dir_i(dir_i),
        .pos_valid_i(pos_valid_i), .pos_ready_o(pos_ready_o),
        .hs_o(hs_o), .vs_o(vs_o), .col_o(col_o), .frame_o(frame_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // drive one pixel and check the colour two edges later
    task automatic pix(input string tag, input logic [10:0] x, input logic [9:0] y,
                       input logic act, input logic [7:0] bg, input logic [7:0] exp);
        pix_x_i = x; pix_y_i = y; active_i = act; bg_col_i = bg;
        step();
        step();
        check(tag, {24'd0, col_o}, {24'd0, exp});
    endtask

    task automatic handshake(input logic [10:0] x, input logic [9:0] y, input logic [1:0] d);
        pos_x_i = x; pos_y_i = y; dir_i = d; pos_valid_i = 1'b1;
        step();
        pos_valid_i = 1'b0;
    endtask

    task automatic vs_pulse();
        vs_i = 1'b1;
        step();
        vs_i = 1'b0;
        step();
    endtask

    logic [7:0] hs_pat, vs_pat;

    initial begin
        // reset state, with live-looking inputs driven
        hs_i = 1'b1; pix_x_i = 11'd640; pix_y_i = 10'd360; active_i = 1'b1; bg_col_i = 8'h5A;
        repeat (3) step();
        check("rst_col", {24'd0, col_o}, 32'h0);
        check("rst_hs", {31'd0, hs_o}, 32'h0);
        check("rst_vs", {31'd0, vs_o}, 32'h0);
        check("rst_frame", {31'd0, frame_o}, 32'h0);
        check("rst_ready", {31'd0, pos_ready_o}, 32'h1);
        hs_i = 1'b0;
        rstn_i = 1'b1;
        step();

        // init position (632,352), mouth closed
        pix("init_centre", 11'd640, 10'd360, 1'b1, 8'h00, 8'hFC);
        pix("init_left_out", 11'd631, 10'd360, 1'b1, 8'h00, 8'h00);
        pix("init_left_bg", 11'd631, 10'd360, 1'b1, 8'h5A, 8'h5A);
        pix("inactive", 11'd640, 10'd360, 1'b0, 8'h5A, 8'h00);

        // buffered move to (100,50) RIGHT, no effect until vsync rise
        handshake(11'd100, 10'd50, 2'd0);
        check("pend_ready", {31'd0, pos_ready_o}, 32'h0);
        pix("pend_old_pos", 11'd640, 10'd360, 1'b1, 8'h11, 8'hFC);
        pix("pend_new_pos", 11'd108, 10'd58, 1'b1, 8'h11, 8'h11);

        // vsync rise #1: commit; frame_o aligned with vs_o
        vs_i = 1'b1;
        step();
        check("frame_early", {31'd0, frame_o}, 32'h0);
        step();
        check("frame_pulse", {31'd0, frame_o}, 32'h1);
        check("frame_vs_o", {31'd0, vs_o}, 32'h1);
        vs_i = 1'b0;
        step();
        check("frame_once", {31'd0, frame_o}, 32'h0);
        check("commit_ready", {31'd0, pos_ready_o}, 32'h1);
        pix("commit_new", 11'd108, 10'd58, 1'b1, 8'h11, 8'hFC);
        pix("commit_old", 11'd640, 10'd360, 1'b1, 8'h11, 8'h11);
        pix("closed_front", 11'd114, 10'd58, 1'b1, 8'h11, 8'hFC);

        // rise #2 -> HALF_A
        vs_pulse();
        pix("half_diag", 11'd110, 10'd60, 1'b1, 8'h22, 8'hFC);
        pix("half_front", 11'd114, 10'd58, 1'b1, 8'h22, 8'h22);

        // rises #3,#4 -> OPEN
        vs_pulse();
        vs_pulse();
        pix("open_diag", 11'd110, 10'd60, 1'b1, 8'h22, 8'h22);
        pix("open_front", 11'd114, 10'd58, 1'b1, 8'h22, 8'h22);
        pix("open_rim_u0", 11'd100, 10'd58, 1'b1, 8'h22, 8'h22);
        pix("open_back", 11'd101, 10'd58, 1'b1, 8'h22, 8'hFC);

        // LEFT, rise #5 stays OPEN
        handshake(11'd100, 10'd50, 2'd1);
        vs_pulse();
        pix("left_mouth", 11'd101, 10'd58, 1'b1, 8'h33, 8'h33);
        pix("left_back", 11'd114, 10'd58, 1'b1, 8'h33, 8'hFC);

        // rise #6 -> HALF_B; UP committed at rise #7
        vs_pulse();
        handshake(11'd100, 10'd50, 2'd2);
        vs_pulse();
        pix("up_mouth", 11'd108, 10'd51, 1'b1, 8'h44, 8'h44);
        pix("up_back", 11'd108, 10'd64, 1'b1, 8'h44, 8'hFC);

        // handshake in the same cycle as rise #8 (-> CLOSED): shadow only
        pos_x_i = 11'd2040; pos_y_i = 10'd50; dir_i = 2'd0; pos_valid_i = 1'b1; vs_i = 1'b1;
        step();
        pos_valid_i = 1'b0; vs_i = 1'b0;
        step();
        check("samecyc_ready", {31'd0, pos_ready_o}, 32'h0);
        pix("samecyc_hold", 11'd108, 10'd51, 1'b1, 8'h44, 8'hFC);
        vs_pulse();
        pix("wrap_in", 11'd4, 10'd58, 1'b1, 8'h55, 8'hFC);
        pix("wrap_out", 11'd2030, 10'd58, 1'b1, 8'h55, 8'h55);

        // sync pass-through pattern, 2-cycle delay
        hs_pat = 8'b1011_0010;
        vs_pat = 8'b0110_1100;
        for (int i = 0; i < 10; i++) begin
            hs_i = (i < 8) ? hs_pat[i] : 1'b0;
            vs_i = (i < 8) ? vs_pat[i] : 1'b0;
            step();
            if (i >= 1 && i <= 8) begin
                check($sformatf("hs_dly%0d", i - 1), {31'd0, hs_o}, {31'd0, hs_pat[i - 1]});
                check($sformatf("vs_dly%0d", i - 1), {31'd0, vs_o}, {31'd0, vs_pat[i - 1]});
            end
        end

        // reset mid-line with a pending update
        handshake(11'd300, 10'd300, 2'd0);
        check("mid_pend", {31'd0, pos_ready_o}, 32'h0);
        hs_i = 1'b1;
        pix("mid_pre", 11'd2041, 10'd58, 1'b1, 8'h00, 8'hFC);
        check("mid_pre_hs", {31'd0, hs_o}, 32'h1);
        #3 rstn_i = 1'b0;
        #1;
        check("mid_rst_col", {24'd0, col_o}, 32'h0);
        check("mid_rst_hs", {31'd0, hs_o}, 32'h0);
        check("mid_rst_ready", {31'd0, pos_ready_o}, 32'h1);
        hs_i = 1'b0;
        step();
        rstn_i = 1'b1;
        step();
        check("post_ready", {31'd0, pos_ready_o}, 32'h1);
        pix("post_init", 11'd640, 10'd360, 1'b1, 8'h66, 8'hFC);
        vs_pulse();
        pix("post_no_commit", 11'd308, 10'd308, 1'b1, 8'h66, 8'h66);
        pix("post_still_init", 11'd640, 10'd360, 1'b1, 8'h66, 8'hFC);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
